xy_switch_scheduler: RTL and testbench

- Sequencer for the simple mesh XY switch crossbar. It picks one input port per packet using round-robin and computes the XY output port from the packet header's destination coordinates.
- It drives mux_in_sel / mux_out_sel into the switch control unit and holds the selection until the packet's tail flit has transferred (wormhole lock).
- It sits between the input FIFO valid flags and the switch control unit and crossbar mux.

---
 rtl/xy_switch_scheduler_if.sv | 30 +++
 rtl/xy_switch_scheduler.sv | 179 +++++++++++++++++
 tb/tb_xy_switch_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_switch_scheduler_if.sv
// Handshake bundle between the input FIFOs / switch control unit and the
// XY switch scheduler. The master drives the per-port request side and
// observes the selections; the slave is the scheduler itself.
interface xy_switch_scheduler_if #(
    parameter int PORT_N  = 5,
    parameter int COORD_W = 4
);
    localparam int SEL_W = $clog2(PORT_N);

    logic [PORT_N-1:0]         vld_input_i;
    logic [PORT_N-1:0]         tail_i;
    logic [PORT_N*COORD_W-1:0] dst_x_i;
    logic [PORT_N*COORD_W-1:0] dst_y_i;
    logic [PORT_N-1:0]         full_i;
    logic [SEL_W-1:0]          mux_in_sel_o;
    logic [SEL_W-1:0]          mux_out_sel_o;
    logic                      sel_vld_o;
    logic                      xfer_o;
    logic                      timeout_o;

    modport master (
        output vld_input_i, tail_i, dst_x_i, dst_y_i, full_i,
        input  mux_in_sel_o, mux_out_sel_o, sel_vld_o, xfer_o, timeout_o
    );

    modport slave (
        input  vld_input_i, tail_i, dst_x_i, dst_y_i, full_i,
        output mux_in_sel_o, mux_out_sel_o, sel_vld_o, xfer_o, timeout_o
    );
endinterface

// File: rtl/xy_switch_scheduler.sv
// XY switch scheduler: round-robin input grant, XY output routing and a
// wormhole lock held until the packet's tail flit transfers.
// Optional stall watchdog compiled in with `define SCHED_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no packet owns the crossbar; round-robin search from rr_ptr
// ST_LOCKED | in/out selections frozen until the tail flit transfers
module xy_switch_scheduler #(
    parameter int PORT_N      = 5,
    parameter int COORD_W     = 4,
    parameter int X_COORD     = 0,
    parameter int Y_COORD     = 0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    xy_switch_scheduler_if.slave  bus
);
    localparam int SEL_W = $clog2(PORT_N);

    localparam logic [COORD_W-1:0] X_C       = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] Y_C       = COORD_W'(Y_COORD);
    localparam logic [SEL_W-1:0]   LAST_PORT = SEL_W'(PORT_N - 1);

    localparam logic [SEL_W-1:0] PORT_LOCAL = SEL_W'(0);
    localparam logic [SEL_W-1:0] PORT_NORTH = SEL_W'(1);
    localparam logic [SEL_W-1:0] PORT_EAST  = SEL_W'(2);
    localparam logic [SEL_W-1:0] PORT_SOUTH = SEL_W'(3);
    localparam logic [SEL_W-1:0] PORT_WEST  = SEL_W'(4);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [SEL_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [SEL_W-1:0] in_sel_q,  in_sel_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             sel_vld_q, sel_vld_d;

`ifdef SCHED_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q,   timeout_d;
`endif

    logic [SEL_W-1:0] route [PORT_N];
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand;
    logic             xfer;
    logic [SEL_W-1:0] next_after_in;

    // X is resolved before Y; unsigned compares against this router's position.
    function automatic logic [SEL_W-1:0] xy_route(input logic [COORD_W-1:0] dx,
                                                  input logic [COORD_W-1:0] dy);
        if (dx > X_C)      return PORT_EAST;
        else if (dx < X_C) return PORT_WEST;
        else if (dy > Y_C) return PORT_NORTH;
        else if (dy < Y_C) return PORT_SOUTH;
        else               return PORT_LOCAL;
    endfunction

    // Per-input output port from the head flit's destination.
    always_comb begin
        for (int i = 0; i < PORT_N; i++) begin
            route[i] = xy_route(bus.dst_x_i[i*COORD_W +: COORD_W],
                                bus.dst_y_i[i*COORD_W +: COORD_W]);
        end
    end

    // Round-robin search: first valid input at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = rr_ptr_q;
        for (int k = 0; k < PORT_N; k++) begin
            if (!grant_found && bus.vld_input_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == LAST_PORT) ? '0 : cand + 1'b1;
        end
    end

    // A flit moves when the locked source has data and the locked output has room.
    assign xfer = (state_q == ST_LOCKED) &&
                  bus.vld_input_i[in_sel_q] && !bus.full_i[out_sel_q];

    assign next_after_in = (in_sel_q == LAST_PORT) ? '0 : in_sel_q + 1'b1;

    // Next-state: grant in IDLE, release on tail transfer (or watchdog) in LOCKED.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
`ifdef SCHED_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d   = ST_LOCKED;
                    in_sel_d  = grant_idx;
                    out_sel_d = route[grant_idx];
`ifdef SCHED_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
`ifdef SCHED_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                    if (bus.tail_i[in_sel_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_after_in;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (stall_cnt_q == CNT_LAST) begin
                    // This stalled cycle is the TIMEOUT_CYC-th in a row: abandon the packet.
                    state_d     = ST_IDLE;
                    rr_ptr_d    = next_after_in;
                    stall_cnt_d = '0;
                    timeout_d   = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        sel_vld_d = (state_d == ST_LOCKED);
    end

    // All scheduler state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            in_sel_q  <= '0;
            out_sel_q <= '0;
            sel_vld_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
            sel_vld_q <= sel_vld_d;
`ifdef SCHED_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.mux_in_sel_o  = in_sel_q;
    assign bus.mux_out_sel_o = out_sel_q;
    assign bus.sel_vld_o     = sel_vld_q;
    assign bus.xfer_o        = xfer;
`ifdef SCHED_TIMEOUT_EN
    assign bus.timeout_o     = timeout_q;
`else
    assign bus.timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_xy_switch_scheduler.sv
// Bench for xy_switch_scheduler at router (1,1): directed scenarios plus
// random traffic, every cycle compared against a packet-level model.
module tb_xy_switch_scheduler;
    localparam int PN = 5;
    localparam int CW = 4;
    localparam int XC = 1;
    localparam int YC = 1;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xy_switch_scheduler_if #(.PORT_N(PN), .COORD_W(CW)) bus ();

    xy_switch_scheduler #(
        .PORT_N(PN), .COORD_W(CW), .X_COORD(XC), .Y_COORD(YC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: who owns the crossbar and where the next search starts
    bit m_locked;
    int m_in, m_out, m_rr, m_stall;
    bit m_to;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int route_ref(input int dx, input int dy);
        if (dx > XC) return 2;
        if (dx < XC) return 4;
        if (dy > YC) return 1;
        if (dy < YC) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_in = 0; m_out = 0; m_rr = 0; m_stall = 0; m_to = 0;
    endtask

    task automatic drive_idle();
        bus.vld_input_i = '0;
        bus.tail_i      = '0;
        bus.full_i      = '0;
        bus.dst_x_i     = '0;
        bus.dst_y_i     = '0;
    endtask

    task automatic set_dst(input int p, input int x, input int y);
        bus.dst_x_i[p*CW +: CW] = CW'(x);
        bus.dst_y_i[p*CW +: CW] = CW'(y);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        int  exp_xfer;
        bit  n_locked, n_to, found;
        int  n_in, n_out, n_rr, n_stall;
        @(negedge clk);
        exp_xfer = (m_locked && bus.vld_input_i[m_in] && !bus.full_i[m_out]) ? 1 : 0;
        chk("sel_vld", int'(bus.sel_vld_o), int'(m_locked));
        chk("in_sel", int'(bus.mux_in_sel_o), m_in);
        chk("out_sel", int'(bus.mux_out_sel_o), m_out);
        chk("xfer", int'(bus.xfer_o), exp_xfer);
        chk("timeout", int'(bus.timeout_o), int'(m_to));
        n_locked = m_locked; n_in = m_in; n_out = m_out; n_rr = m_rr;
        n_stall = m_stall; n_to = 0; found = 0;
        if (!m_locked) begin
            for (int k = 0; k < PN; k++) begin
                int i;
                i = (m_rr + k) % PN;
                if (!found && bus.vld_input_i[i]) begin
                    found = 1; n_locked = 1; n_in = i; n_stall = 0;
                    n_out = route_ref(int'(bus.dst_x_i[i*CW +: CW]), int'(bus.dst_y_i[i*CW +: CW]));
                end
            end
        end else if (exp_xfer == 1) begin
            n_stall = 0;
            if (bus.tail_i[m_in]) begin
                n_locked = 0;
                n_rr = (m_in + 1) % PN;
            end
        end else begin
`ifdef SCHED_TIMEOUT_EN
            n_stall = m_stall + 1;
            if (n_stall == TO) begin
                n_locked = 0; n_rr = (m_in + 1) % PN; n_stall = 0; n_to = 1;
            end
`endif
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_locked = n_locked; m_in = n_in; m_out = n_out; m_rr = n_rr;
            m_stall = n_stall; m_to = n_to;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int grants[$];
    int exp_order[6] = '{1, 3, 4, 1, 3, 4};
    bit prev_vld;

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_vld", int'(bus.sel_vld_o), 0);
        chk("rst_in_sel", int'(bus.mux_in_sel_o), 0);
        chk("rst_out_sel", int'(bus.mux_out_sel_o), 0);
        chk("rst_xfer", int'(bus.xfer_o), 0);
        chk("rst_timeout", int'(bus.timeout_o), 0);
        rst = 1'b0;

        // single-flit packet east, then rr_ptr advanced to 1
        bus.vld_input_i = 5'b00001; bus.tail_i = 5'b00001; set_dst(0, 3, 1);
        cyc();
        chk("t1_sel_vld", int'(bus.sel_vld_o), 1);
        chk("t1_in_sel", int'(bus.mux_in_sel_o), 0);
        chk("t1_out_sel", int'(bus.mux_out_sel_o), 2);
        chk("t1_xfer", int'(bus.xfer_o), 1);
        cyc();
        chk("t1_release", int'(bus.sel_vld_o), 0);
        bus.vld_input_i = 5'b00011; bus.tail_i = 5'b00011; set_dst(1, 1, 3);
        cyc();
        chk("t1_rr_next", int'(bus.mux_in_sel_o), 1);
        cyc();
        drive_idle();
        cyc();

        // round-robin among inputs 1, 3, 4 with continuous single-flit traffic
        do_reset();
        bus.vld_input_i = 5'b11010; bus.tail_i = 5'b11111;
        set_dst(1, 0, 0); set_dst(3, 2, 2); set_dst(4, 1, 0);
        for (int c = 0; c < 12; c++) begin
            prev_vld = bus.sel_vld_o;
            cyc();
            if (!prev_vld && bus.sel_vld_o) grants.push_back(int'(bus.mux_in_sel_o));
        end
        chk("t2_ngrants", grants.size(), 6);
        for (int g = 0; g < 6; g++)
            chk("t2_order", (g < grants.size()) ? grants[g] : -1, exp_order[g]);
        drive_idle();
        cyc();

        // 3-flit packet south, output full for 4 cycles, dst changed mid-packet
        do_reset();
        bus.vld_input_i = 5'b00100; set_dst(2, 1, 0);
        cyc();
        bus.full_i = 5'b01000;
        #1;
        chk("t3_out_sel", int'(bus.mux_out_sel_o), 3);
        for (int c = 0; c < 4; c++) begin
            chk("t3_stall_xfer", int'(bus.xfer_o), 0);
            if (c == 0) set_dst(2, 3, 3);
            cyc();
        end
        bus.full_i = '0;
        cyc();
        cyc();
        chk("t3_body_hold", int'(bus.sel_vld_o), 1);
        chk("t3_out_frozen", int'(bus.mux_out_sel_o), 3);
        bus.tail_i = 5'b00100;
        #1;
        chk("t3_tail_xfer", int'(bus.xfer_o), 1);
        cyc();
        chk("t3_release", int'(bus.sel_vld_o), 0);
        drive_idle();
        cyc();

        // local delivery and X-before-Y resolution
        do_reset();
        bus.vld_input_i = 5'b00001; bus.tail_i = 5'b00001; set_dst(0, 1, 1);
        cyc();
        chk("t4_local", int'(bus.mux_out_sel_o), 0);
        cyc();
        set_dst(0, 0, 2);
        cyc();
        chk("t4_west", int'(bus.mux_out_sel_o), 4);
        cyc();
        drive_idle();
        cyc();

        // asynchronous reset mid-packet, search restarts from input 0
        do_reset();
        bus.vld_input_i = 5'b01000; set_dst(3, 2, 1);
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_vld", int'(bus.sel_vld_o), 0);
        chk("t5_async_xfer", int'(bus.xfer_o), 0);
        model_reset();
        cyc();
        rst = 1'b0;
        bus.vld_input_i = 5'b10100; bus.tail_i = 5'b10100;
        set_dst(2, 1, 2); set_dst(4, 2, 0);
        cyc();
        chk("t5_restart", int'(bus.mux_in_sel_o), 2);
        cyc();
        drive_idle();
        cyc();

        // granted source goes quiet
        do_reset();
        bus.vld_input_i = 5'b00010; set_dst(1, 1, 2);
        cyc();
        bus.vld_input_i = '0;
`ifdef SCHED_TIMEOUT_EN
        repeat (TO) cyc();
        chk("t6_timeout", int'(bus.timeout_o), 1);
        chk("t6_released", int'(bus.sel_vld_o), 0);
        bus.vld_input_i = 5'b00101; bus.tail_i = 5'b00101;
        cyc();
        chk("t6_next_search", int'(bus.mux_in_sel_o), 2);
`else
        repeat (20) cyc();
        chk("t6_lock_held", int'(bus.sel_vld_o), 1);
        chk("t6_no_timeout", int'(bus.timeout_o), 0);
        chk("t6_in_held", int'(bus.mux_in_sel_o), 1);
`endif
        drive_idle();

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < PN; i++) begin
                bus.vld_input_i[i] = ($urandom_range(0, 9) < 6);
                bus.tail_i[i]      = ($urandom_range(0, 2) == 0);
                bus.full_i[i]      = ($urandom_range(0, 3) == 0);
                set_dst(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
